uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_fifo.sv | 39 +++
 rtl/uart_tx.sv | 72 +++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state type shared by the UART transmit and receive sides.
package uart_pkg;
    localparam int CLK_FREQ   = 12000000;
    localparam int BAUD       = 9600;
    localparam int DIV        = CLK_FREQ / BAUD;
    localparam int FRAME_BITS = 10;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with registered occupancy count and full/empty flags.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    // Full is judged on the registered count, so a same-edge pop never frees room for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter; FIFO front end, FSM, baud counter and shift register.
module uart_tx #(
    parameter int CLK_FREQ   = uart_pkg::CLK_FREQ,
    parameter int BAUD       = uart_pkg::BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import uart_pkg::*;
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    uart_state_t state;
    logic [10:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift, head;
    logic        full, empty, pop, bit_done;
    assign bit_done = baud_cnt == 11'(BIT_CYC - 1);
    assign pop      = !empty && (state == IDLE || (state == STOP && bit_done));
    assign tx_ready = !full;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (tx_valid),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
    // Line outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            tx_busy   <= state != IDLE;
            tx_serial <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
            baud_cnt  <= bit_done || state == IDLE ? '0 : baud_cnt + 11'd1;
            case (state)
                IDLE: if (pop) begin
                    shift <= head;
                    state <= START;
                end
                START: if (bit_done) begin
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (bit_done) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (bit_done) begin
                    if (pop) shift <= head;
                    state <= pop ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; a loopback receiver pops expected bytes as frames arrive.
module tb_uart_tx;
    localparam int CLK_FREQ = 120000;
    localparam int BAUD     = 9600;
    localparam int DIV      = 12;
    localparam int DEPTH    = 4;
    localparam int TMO      = 20 * DIV;

    logic       clk = 1'b0, nrst = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_serial, tx_busy;
    logic [2:0] fifo_count;
    int         cyc = 0, checks = 0, errors = 0, frames = 0;
    logic [7:0] exp_q[$];
    int         starts_q[$];

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance with tx_valid still high.
    task automatic send(input logic [7:0] b, output int acc);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        acc      = -1;
        while (!tx_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            chk("send timeout", n, -1);
            return;
        end
        @(posedge clk);
        exp_q.push_back(b);
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || fifo_count != 0) && n < 100 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n < 100 * DIV), 1);
    endtask

    // Loopback receive stage: samples the middle of each bit after a detected start edge.
    initial begin
        logic       act = 1'b0;
        int         cnt = 0;
        logic [9:0] fr  = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!nrst) act = 1'b0;
            else if (!act) begin
                if (!tx_serial) begin
                    act = 1'b1;
                    cnt = 0;
                    starts_q.push_back(cyc);
                end
            end else cnt++;
            if (act && cnt % DIV == DIV / 2) begin
                fr[cnt / DIV] = tx_serial;
                if (cnt / DIV == 9) begin
                    act = 1'b0;
                    frames++;
                    if (exp_q.size() == 0) chk("unexpected frame", int'(fr), -1);
                    else begin
                        e = exp_q.pop_front();
                        chk("rx frame", int'(fr), int'({1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    initial begin
        int         a, a5, a6, n, n0;
        logic [9:0] w = 10'h2AA;
        repeat (3) @(negedge clk);
        chk("reset tx_serial", tx_serial, 1);
        chk("reset tx_busy", tx_busy, 0);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset tx_ready", tx_ready, 1);
        nrst = 1'b1;
        @(negedge clk);
        // 0x55: cycle-exact line check
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk);
        exp_q.push_back(8'h55);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept count", fifo_count, 1);
        @(negedge clk);
        chk("pop count", fifo_count, 0);
        chk("line before start", tx_serial, 1);
        chk("busy before start", tx_busy, 0);
        for (int c = 0; c < 10 * DIV; c++) begin
            @(negedge clk);
            chk("0x55 line", tx_serial, int'(w[c / DIV]));
            chk("0x55 busy", tx_busy, 1);
        end
        @(negedge clk);
        chk("line after stop", tx_serial, 1);
        chk("busy after stop", tx_busy, 0);
        wait_drain("drain 0x55");
        // back-to-back frames
        n0 = starts_q.size();
        send(8'hA5, a);
        send(8'h3C, a);
        tx_valid = 1'b0;
        wait_drain("drain a5/3c");
        chk("b2b start spacing", starts_q[n0 + 1] - starts_q[n0], 10 * DIV);
        // six bytes with tx_valid held high
        send(8'h01, a);
        send(8'h02, a);
        send(8'h03, a);
        send(8'h04, a);
        send(8'h05, a5);
        chk("full count", fifo_count, 4);
        chk("full ready", tx_ready, 0);
        send(8'h06, a6);
        tx_valid = 1'b0;
        chk("6th accept delay", a6 - a5, 10 * DIV - 2);
        wait_drain("drain six");
        // push held across a pop while full is refused
        send(8'h10, a);
        send(8'h11, a);
        send(8'h12, a);
        send(8'h13, a);
        send(8'h14, a);
        tx_data = 8'hEE;
        n = 0;
        while (fifo_count == 3'd4 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        chk("refused push count", fifo_count, 3);
        wait_drain("drain refused");
        // reset mid-frame with queued bytes and a push on the reset edge
        send(8'h00, a);
        send(8'h11, a);
        send(8'h22, a);
        tx_valid = 1'b0;
        repeat (29) @(negedge clk);
        chk("mid-frame line", tx_serial, 0);
        nrst     = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        @(negedge clk);
        chk("abort tx_serial", tx_serial, 1);
        chk("abort fifo_count", fifo_count, 0);
        chk("abort tx_busy", tx_busy, 0);
        chk("abort tx_ready", tx_ready, 1);
        exp_q.delete();
        tx_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        n0   = frames;
        repeat (25 * DIV) @(negedge clk);
        chk("no frames after reset", frames, n0);
        chk("idle count after reset", fifo_count, 0);
        chk("idle line after reset", tx_serial, 1);
        // loopback bytes
        send(8'h00, a);
        send(8'hFF, a);
        send(8'h81, a);
        tx_valid = 1'b0;
        wait_drain("drain loopback");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
